// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters that
// returns a same-cycle next-PC prediction for the fetch PC and trains from
// branch/jump/jr outcomes resolved in decode.
// Optional feature: define BPU_RAS_EN to add a circular return-address stack
// that overrides the BTB target for RET entries while it holds addresses.
module branch_predictor #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_IF,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            hold,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [1:0]      upd_type,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            ras_push,
    input  logic [PC_W-1:0] ras_push_addr,
    input  logic            ras_pop
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W;

    localparam int unsigned CTR_WT_I = 1 << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(CTR_WT_I);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(CTR_WT_I - 1);

    localparam logic [1:0] T_COND = 2'b00;
    localparam logic [1:0] T_RET  = 2'b10;
    localparam logic [1:0] T_RSVD = 2'b11;

    // BTB storage; only valid and ctr carry reset values
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [1:0]         type_q   [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    // Return-address stack view used by the lookup path
    logic               ras_valid;
    logic [PC_W-1:0]    ras_top;

    // Lookup-side signals
    logic [IDX_W-1:0]   rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_hit;
    logic [1:0]         rd_type;

    // Training-side signals
    logic [IDX_W-1:0]   wr_idx;
    logic [TAG_W-1:0]   wr_tag;
    logic               wr_hit;
    logic               train;
    logic               wr_en;
    logic [CTR_W-1:0]   cur_ctr;
    logic [CTR_W-1:0]   new_ctr;

    assign rd_idx = pc_IF[IDX_W-1:0];
    assign rd_tag = pc_IF[PC_W-1:IDX_W];
    assign wr_idx = upd_pc[IDX_W-1:0];
    assign wr_tag = upd_pc[PC_W-1:IDX_W];

    // Combinational lookup from the flopped tables (pre-update contents)
    always_comb begin
        rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_type     = type_q[rd_idx];
        pred_taken  = 1'b0;
        pred_target = pc_IF + PC_W'(1);
        if (rd_hit && ((rd_type != T_COND) || ctr_q[rd_idx][CTR_W-1])) begin
            pred_taken = 1'b1;
            if ((rd_type == T_RET) && ras_valid) begin
                pred_target = ras_top;
            end else begin
                pred_target = target_q[rd_idx];
            end
        end
    end

    // Decide whether and how the resolved instruction updates its entry
    always_comb begin
        train   = upd_en && !hold && (upd_type != T_RSVD);
        wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        cur_ctr = ctr_q[wr_idx];
        wr_en   = 1'b0;
        new_ctr = cur_ctr;
        if (train) begin
            if (wr_hit) begin
                wr_en = 1'b1;
                if (upd_type == T_COND) begin
                    if (upd_taken) begin
                        new_ctr = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + CTR_W'(1);
                    end else begin
                        new_ctr = (cur_ctr == '0) ? cur_ctr : cur_ctr - CTR_W'(1);
                    end
                end else begin
                    new_ctr = CTR_MAX;
                end
            end else if (upd_taken) begin
                // Allocation replaces whatever currently occupies the index
                wr_en   = 1'b1;
                new_ctr = (upd_type == T_COND) ? CTR_WT : CTR_MAX;
            end
        end
    end

    // BTB state update; reset wins over a same-cycle training write
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wr_en) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= upd_target;
            type_q[wr_idx]   <= upd_type;
            ctr_q[wr_idx]    <= new_ctr;
        end
    end

`ifdef BPU_RAS_EN
    localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CW = RAS_PW + 1;

    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
    logic [RAS_PW-1:0] ras_ptr;
    logic [RAS_CW-1:0] ras_cnt;
    logic [RAS_PW-1:0] ras_top_idx;

    assign ras_top_idx = ras_ptr - RAS_PW'(1);
    assign ras_valid   = (ras_cnt != '0);
    assign ras_top     = ras_mem[ras_top_idx];

    // Circular stack: full push overwrites oldest, empty pop is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (!hold) begin
            if (ras_push && ras_pop && ras_valid) begin
                ras_mem[ras_top_idx] <= ras_push_addr;
            end else if (ras_push) begin
                ras_mem[ras_ptr] <= ras_push_addr;
                ras_ptr          <= ras_ptr + RAS_PW'(1);
                if (ras_cnt != RAS_CW'(RAS_DEPTH)) begin
                    ras_cnt <= ras_cnt + RAS_CW'(1);
                end
            end else if (ras_pop && ras_valid) begin
                ras_ptr <= ras_ptr - RAS_PW'(1);
                ras_cnt <= ras_cnt - RAS_CW'(1);
            end
        end
    end
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;

    // Without the stack, RET entries fall back to their stored BTB target
    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
    assign ras_valid  = 1'b0;
    assign ras_top    = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected predictions,
// a negedge monitor pops and compares whenever a probe is presented.
module tb_branch_predictor;

    localparam int unsigned PC_W = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] pc_IF;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            hold;
    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic [1:0]      upd_type;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            ras_push;
    logic [PC_W-1:0] ras_push_addr;
    logic            ras_pop;

    logic            probe_en;
    logic            exp_taken_q [$];
    logic [PC_W-1:0] exp_tgt_q   [$];
    string           name_q      [$];
    int              checks   = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .PC_W(PC_W), .ENTRIES(16), .CTR_W(2), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .pc_IF(pc_IF),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .hold(hold), .upd_en(upd_en), .upd_pc(upd_pc), .upd_type(upd_type),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop)
    );

    // Monitor: compare DUT prediction against the scoreboard head
    always @(negedge clk) begin
        if (probe_en) begin
            if (exp_taken_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: probe with no expected entry");
            end else begin
                logic            et;
                logic [PC_W-1:0] eg;
                string           nm;
                et = exp_taken_q.pop_front();
                eg = exp_tgt_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (pred_taken !== et) begin
                    failures++;
                    $display("FAIL %s taken: got %b want %b", nm, pred_taken, et);
                end
                checks++;
                if (pred_target !== eg) begin
                    failures++;
                    $display("FAIL %s target: got 0x%03h want 0x%03h", nm, pred_target, eg);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [PC_W-1:0] pc, input logic [1:0] ty,
                         input logic tk, input logic [PC_W-1:0] tg);
        upd_en = 1'b1; upd_pc = pc; upd_type = ty; upd_taken = tk; upd_target = tg;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic probe(input logic [PC_W-1:0] pc, input logic et,
                         input logic [PC_W-1:0] eg, input string nm);
        pc_IF = pc;
        exp_taken_q.push_back(et);
        exp_tgt_q.push_back(eg);
        name_q.push_back(nm);
        probe_en = 1'b1;
        tick();
        probe_en = 1'b0;
    endtask

    task automatic ras_op(input logic push, input logic pop, input logic [PC_W-1:0] addr);
        ras_push = push; ras_pop = pop; ras_push_addr = addr;
        tick();
        ras_push = 1'b0; ras_pop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; pc_IF = '0; hold = 1'b0; upd_en = 1'b0; upd_pc = '0;
        upd_type = 2'b00; upd_taken = 1'b0; upd_target = '0;
        ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0; probe_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state and fall-through wrap
        probe(10'h005, 1'b0, 10'h006, "reset_fallthrough");
        probe(10'h3FF, 1'b0, 10'h000, "reset_wrap");

        // Conditional branch counter training
        train(10'h012, 2'b00, 1'b1, 10'h040);
        probe(10'h012, 1'b1, 10'h040, "cond_alloc_taken");
        train(10'h012, 2'b00, 1'b0, 10'h040);
        train(10'h012, 2'b00, 1'b0, 10'h040);
        probe(10'h012, 1'b0, 10'h013, "cond_two_not_taken");
        repeat (3) train(10'h012, 2'b00, 1'b1, 10'h040);
        train(10'h012, 2'b00, 1'b0, 10'h040);
        probe(10'h012, 1'b1, 10'h040, "cond_hysteresis");

        // Aliasing on index 2
        train(10'h022, 2'b00, 1'b1, 10'h100);
        probe(10'h012, 1'b0, 10'h013, "alias_old_miss");
        probe(10'h022, 1'b1, 10'h100, "alias_new_hit");

        // Hold blocks training; release trains exactly once
        hold = 1'b1;
        upd_en = 1'b1; upd_pc = 10'h022; upd_type = 2'b00; upd_taken = 1'b0; upd_target = 10'h100;
        repeat (3) tick();
        hold = 1'b0;
        probe(10'h022, 1'b1, 10'h100, "same_cycle_old_value");
        upd_en = 1'b0;
        probe(10'h022, 1'b0, 10'h023, "hold_one_step_down");
        train(10'h022, 2'b00, 1'b1, 10'h100);
        probe(10'h022, 1'b1, 10'h100, "hold_one_step_up");

        // Jump, reserved type, not-taken miss
        train(10'h0A5, 2'b01, 1'b1, 10'h200);
        probe(10'h0A5, 1'b1, 10'h200, "jump_alloc");
        train(10'h0B7, 2'b11, 1'b1, 10'h300);
        probe(10'h0B7, 1'b0, 10'h0B8, "reserved_ignored");
        train(10'h0C8, 2'b00, 1'b0, 10'h123);
        probe(10'h0C8, 1'b0, 10'h0C9, "not_taken_miss_no_alloc");

        // Reset beats a same-cycle allocate
        rst = 1'b1;
        upd_en = 1'b1; upd_pc = 10'h033; upd_type = 2'b00; upd_taken = 1'b1; upd_target = 10'h050;
        tick();
        rst = 1'b0; upd_en = 1'b0;
        probe(10'h033, 1'b0, 10'h034, "reset_drops_update");
        probe(10'h0A5, 1'b0, 10'h0A6, "reset_clears_btb");

`ifdef BPU_RAS_EN
        // Return-address stack behaviour
        ras_op(1'b1, 1'b0, 10'h011);
        ras_op(1'b1, 1'b0, 10'h021);
        hold = 1'b1;
        ras_op(1'b0, 1'b1, 10'h000);
        hold = 1'b0;
        train(10'h030, 2'b10, 1'b1, 10'h077);
        probe(10'h030, 1'b1, 10'h021, "ras_top_after_hold_pop");
        ras_op(1'b0, 1'b1, 10'h000);
        probe(10'h030, 1'b1, 10'h011, "ras_pop_one");
        ras_op(1'b0, 1'b1, 10'h000);
        probe(10'h030, 1'b1, 10'h077, "ras_empty_btb");
        ras_op(1'b0, 1'b1, 10'h000);
        probe(10'h030, 1'b1, 10'h077, "ras_pop_on_empty");
        ras_op(1'b1, 1'b0, 10'h0AA);
        ras_op(1'b1, 1'b1, 10'h0BB);
        probe(10'h030, 1'b1, 10'h0BB, "ras_push_pop_replace");
        ras_op(1'b0, 1'b1, 10'h000);
        probe(10'h030, 1'b1, 10'h077, "ras_replace_keeps_count");
        for (int i = 1; i <= 5; i++) ras_op(1'b1, 1'b0, PC_W'(10'h100 + i));
        probe(10'h030, 1'b1, 10'h105, "ras_full_top");
        repeat (3) ras_op(1'b0, 1'b1, 10'h000);
        probe(10'h030, 1'b1, 10'h102, "ras_full_after_three_pops");
        ras_op(1'b0, 1'b1, 10'h000);
        probe(10'h030, 1'b1, 10'h077, "ras_oldest_lost");
`else
        // Without the stack, RET uses the BTB target and RAS ops are ignored
        ras_op(1'b1, 1'b0, 10'h011);
        train(10'h030, 2'b10, 1'b1, 10'h077);
        probe(10'h030, 1'b1, 10'h077, "ret_btb_target");
`endif

        repeat (2) tick();
        checks++;
        if (exp_taken_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_taken_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
